// File: rtl/menu_ctrl.sv
// Menu navigation/edit controller: debounces four front-panel buttons and turns them into
// overlay state (on/off, selected line, edit mode) plus committed parameter values.
module menu_ctrl #(
    parameter int          bit_data_in = 20,
    parameter int          DEB_CYC     = 50000,
    parameter int          REP_DLY     = 30,
    parameter int          REP_PER     = 4,
    parameter int          TIMEOUT     = 600,
    parameter logic [31:0] MAX_MODE    = 32'd3,
    parameter logic [31:0] MAX_AGC     = 32'd1,
    parameter logic [31:0] MAX_LVL     = 32'h000FFFFF,
    parameter logic [31:0] MAX_TINT    = 32'h000003FF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   newframe,
    input  logic                   btn_menu,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_enter,
    output logic                   menu_on,
    output logic [2:0]             sel_item,
    output logic                   edit_active,
    output logic [bit_data_in-1:0] out_mode,
    output logic [bit_data_in-1:0] out_Type_AGC,
    output logic [bit_data_in-1:0] out_Set_LVL1,
    output logic [bit_data_in-1:0] out_Set_LVL2,
    output logic [bit_data_in-1:0] out_Time_int,
    output logic [bit_data_in-1:0] shadow_val,
    output logic                   cfg_update
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [bit_data_in-1:0] LIM_MODE = bit_data_in'(MAX_MODE);
    localparam logic [bit_data_in-1:0] LIM_AGC  = bit_data_in'(MAX_AGC);
    localparam logic [bit_data_in-1:0] LIM_LVL  = bit_data_in'(MAX_LVL);
    localparam logic [bit_data_in-1:0] LIM_TINT = bit_data_in'(MAX_TINT);

    typedef enum logic [1:0] {OFF, NAV, EDIT, COMMIT} state_t;
    state_t state;

    // Button bit order: 0 menu, 1 enter, 2 up, 3 down
    logic [3:0]    raw, sync1, sync2, deb, deb_q, evt;
    logic [CW-1:0] cnt [4];

    assign raw = {btn_down, btn_up, btn_enter, btn_menu};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            evt   <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            evt   <= deb & ~deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYC - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat: first REP_DLY frames of hold, then one event every REP_PER frames
    logic [15:0] rep_cnt, rep_ph;
    logic        rep_evt, held;

    assign held = (state == EDIT) && (deb[2] || deb[3]);

    always_ff @(posedge clk) begin
        if (rst || !held) begin
            rep_cnt <= '0;
            rep_ph  <= '0;
            rep_evt <= 1'b0;
        end else begin
            rep_evt <= 1'b0;
            if (newframe) begin
                if (rep_cnt < 16'(REP_DLY)) begin
                    rep_cnt <= rep_cnt + 16'd1;
                    rep_evt <= (rep_cnt == 16'(REP_DLY - 1));
                end else if (rep_ph == 16'(REP_PER - 1)) begin
                    rep_ph  <= '0;
                    rep_evt <= 1'b1;
                end else begin
                    rep_ph <= rep_ph + 16'd1;
                end
            end
        end
    end

    logic up_e, down_e, act_menu, act_enter, act_up, act_down;
    logic [bit_data_in-1:0] cur_val, cur_max;

    always_comb begin
        up_e      = evt[2] || (rep_evt && deb[2]);
        down_e    = evt[3] || (rep_evt && !deb[2] && deb[3]);
        act_menu  = evt[0];
        act_enter = evt[1] && !evt[0];
        act_up    = up_e && !evt[0] && !evt[1];
        act_down  = down_e && !up_e && !evt[0] && !evt[1];
        cur_val   = '0;
        cur_max   = '0;
        case (sel_item)
            3'd0: begin cur_val = out_mode;     cur_max = LIM_MODE; end
            3'd1: begin cur_val = out_Type_AGC; cur_max = LIM_AGC;  end
            3'd2: begin cur_val = out_Set_LVL1; cur_max = LIM_LVL;  end
            3'd3: begin cur_val = out_Set_LVL2; cur_max = LIM_LVL;  end
            3'd4: begin cur_val = out_Time_int; cur_max = LIM_TINT; end
            default: ;
        endcase
    end

    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= OFF;
            menu_on      <= 1'b0;
            sel_item     <= '0;
            edit_active  <= 1'b0;
            out_mode     <= '0;
            out_Type_AGC <= '0;
            out_Set_LVL1 <= '0;
            out_Set_LVL2 <= '0;
            out_Time_int <= '0;
            shadow_val   <= '0;
            cfg_update   <= 1'b0;
            to_cnt       <= '0;
        end else begin
            cfg_update <= 1'b0;
            case (state)
                OFF: begin
                    to_cnt <= '0;
                    if (act_menu) begin
                        state    <= NAV;
                        menu_on  <= 1'b1;
                        sel_item <= '0;
                    end
                end
                NAV: begin
                    if (act_menu) begin
                        state   <= OFF;
                        menu_on <= 1'b0;
                    end else if (act_enter) begin
                        state       <= EDIT;
                        edit_active <= 1'b1;
                        shadow_val  <= cur_val;
                    end else if (act_up) begin
                        sel_item <= (sel_item == 3'd0) ? 3'd4 : sel_item - 3'd1;
                        to_cnt   <= '0;
                    end else if (act_down) begin
                        sel_item <= (sel_item == 3'd4) ? 3'd0 : sel_item + 3'd1;
                        to_cnt   <= '0;
                    end else if (newframe) begin
                        if (to_cnt == TW'(TIMEOUT - 1)) begin
                            state   <= OFF;
                            menu_on <= 1'b0;
                            to_cnt  <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                EDIT: begin
                    to_cnt <= '0;
                    if (act_menu) begin
                        state       <= NAV;
                        edit_active <= 1'b0;
                    end else if (act_enter) begin
                        state       <= COMMIT;
                        edit_active <= 1'b0;
                    end else if (act_up) begin
                        if (shadow_val < cur_max) shadow_val <= shadow_val + 1'b1;
                    end else if (act_down) begin
                        if (shadow_val != '0) shadow_val <= shadow_val - 1'b1;
                    end
                end
                COMMIT: begin
                    to_cnt     <= '0;
                    state      <= NAV;
                    cfg_update <= (shadow_val != cur_val);
                    case (sel_item)
                        3'd0: out_mode     <= shadow_val;
                        3'd1: out_Type_AGC <= shadow_val;
                        3'd2: out_Set_LVL1 <= shadow_val;
                        3'd3: out_Set_LVL2 <= shadow_val;
                        3'd4: out_Time_int <= shadow_val;
                        default: ;
                    endcase
                end
                default: state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed self-checking bench for menu_ctrl with DEB_CYC shortened to 8 clks.
module tb_menu_ctrl;

    localparam int W = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic newframe = 1'b0;
    logic btn_menu = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;
    logic menu_on, edit_active, cfg_update;
    logic [2:0] sel_item;
    logic [W-1:0] out_mode, out_Type_AGC, out_Set_LVL1, out_Set_LVL2, out_Time_int, shadow_val;

    int checks = 0;
    int errors = 0;

    menu_ctrl #(.bit_data_in(W), .DEB_CYC(8)) dut (
        .clk(clk), .rst(rst), .newframe(newframe),
        .btn_menu(btn_menu), .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
        .menu_on(menu_on), .sel_item(sel_item), .edit_active(edit_active),
        .out_mode(out_mode), .out_Type_AGC(out_Type_AGC), .out_Set_LVL1(out_Set_LVL1),
        .out_Set_LVL2(out_Set_LVL2), .out_Time_int(out_Time_int),
        .shadow_val(shadow_val), .cfg_update(cfg_update)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One full press: 0 menu, 1 enter, 2 up, 3 down; release and let debounce settle
    task automatic applyStimulus(input int btn, input int hold);
        case (btn)
            0: btn_menu  = 1'b1;
            1: btn_enter = 1'b1;
            2: btn_up    = 1'b1;
            default: btn_down = 1'b1;
        endcase
        tick(hold);
        btn_menu = 1'b0; btn_enter = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick(12);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            newframe = 1'b1;
            tick(1);
            newframe = 1'b0;
            tick(3);
        end
    endtask

    // Enter from EDIT: event at clk 11, COMMIT at 12, write and pulse visible after clk 13
    task automatic commitEnter(input logic [31:0] exp_val, input logic exp_pulse);
        btn_enter = 1'b1;
        tick(12);
        checkOutput("cfg_update_before_commit", cfg_update, 0);
        tick(1);
        checkOutput("commit_value", out_Type_AGC, exp_val);
        checkOutput("cfg_update_pulse", cfg_update, exp_pulse);
        tick(1);
        checkOutput("cfg_update_cleared", cfg_update, 0);
        checkOutput("commit_back_nav", {30'd0, menu_on, edit_active}, 32'b10);
        tick(6);
        btn_enter = 1'b0;
        tick(12);
    endtask

    initial begin
        // T1: reset with every button held
        btn_menu = 1'b1; btn_up = 1'b1; btn_down = 1'b1; btn_enter = 1'b1;
        tick(2);
        checkOutput("reset_menu_on", menu_on, 0);
        checkOutput("reset_sel", sel_item, 0);
        checkOutput("reset_edit", edit_active, 0);
        checkOutput("reset_shadow", shadow_val, 0);
        checkOutput("reset_values", out_mode | out_Type_AGC | out_Set_LVL1 | out_Set_LVL2 | out_Time_int, 0);
        checkOutput("reset_cfg", cfg_update, 0);
        rst = 1'b0;
        btn_menu = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0;
        tick(30);
        checkOutput("post_reset_off", menu_on, 0);

        // T2: 5-clk glitch is rejected, clean press produces exactly one event at clk 11
        btn_menu = 1'b1;
        tick(5);
        btn_menu = 1'b0;
        tick(20);
        checkOutput("glitch_ignored", menu_on, 0);
        btn_menu = 1'b1;
        tick(11);
        checkOutput("deb_before_event", menu_on, 0);
        tick(1);
        checkOutput("deb_event_latency", menu_on, 1);
        tick(8);
        btn_menu = 1'b0;
        tick(12);
        checkOutput("deb_single_event", menu_on, 1);
        checkOutput("nav_sel_start", sel_item, 0);

        // T3: navigation with wrap, then timeout
        applyStimulus(2, 14);
        checkOutput("nav_up_wrap", sel_item, 4);
        applyStimulus(3, 14);
        checkOutput("nav_down_wrap", sel_item, 0);
        applyStimulus(3, 14);
        checkOutput("nav_down", sel_item, 1);
        tick(200);
        checkOutput("no_frames_no_timeout", menu_on, 1);
        frames(599);
        checkOutput("timeout_not_yet", menu_on, 1);
        frames(1);
        checkOutput("timeout_closes", menu_on, 0);

        // T4: edit item 1 with saturation and commit
        applyStimulus(0, 14);
        applyStimulus(3, 14);
        checkOutput("t4_sel", sel_item, 1);
        applyStimulus(1, 14);
        checkOutput("t4_edit", edit_active, 1);
        applyStimulus(2, 14);
        applyStimulus(2, 14);
        applyStimulus(2, 14);
        checkOutput("agc_saturate", shadow_val, 1);
        commitEnter(1, 1'b1);
        applyStimulus(1, 14);
        checkOutput("t4_shadow_loaded", shadow_val, 1);
        applyStimulus(2, 14);
        commitEnter(1, 1'b0);

        // T5: auto-repeat on item 4, then discard with menu
        applyStimulus(3, 14);
        applyStimulus(3, 14);
        applyStimulus(3, 14);
        checkOutput("t5_sel", sel_item, 4);
        applyStimulus(1, 14);
        applyStimulus(3, 14);
        checkOutput("down_saturate_zero", shadow_val, 0);
        btn_up = 1'b1;
        tick(14);
        checkOutput("repeat_press", shadow_val, 1);
        frames(29);
        checkOutput("repeat_not_started", shadow_val, 1);
        frames(1);
        checkOutput("repeat_first", shadow_val, 2);
        frames(14);
        checkOutput("repeat_total", shadow_val, 5);
        btn_up = 1'b0;
        tick(12);
        applyStimulus(0, 14);
        checkOutput("discard_nav", {30'd0, menu_on, edit_active}, 32'b10);
        checkOutput("discard_unchanged", out_Time_int, 0);

        // T6: simultaneous menu+enter closes the menu; reset aborts an edit
        btn_menu = 1'b1; btn_enter = 1'b1;
        tick(14);
        btn_menu = 1'b0; btn_enter = 1'b0;
        tick(12);
        checkOutput("menu_beats_enter", {30'd0, menu_on, edit_active}, 32'b00);
        applyStimulus(0, 14);
        applyStimulus(1, 14);
        applyStimulus(2, 14);
        applyStimulus(2, 14);
        checkOutput("t6_shadow", shadow_val, 2);
        rst = 1'b1;
        tick(1);
        checkOutput("rst_edit_flags", {29'd0, menu_on, edit_active, cfg_update}, 0);
        checkOutput("rst_shadow", shadow_val, 0);
        checkOutput("rst_agc", out_Type_AGC, 0);
        checkOutput("rst_mode", out_mode, 0);
        rst = 1'b0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
